sap_cpu_core: RTL and testbench

SAP_CPU_CORE -- requirements
Module: sap_cpu_core

---
 rtl/sap_cpu_if.sv | 28 ++
 rtl/sap_cpu_core.sv | 198 +++++++++++++++++++
 tb/tb_sap_cpu_core.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap_cpu_if.sv
// SAP CPU core bus: program-load handshake, run control and the visible
// machine outputs. The master side (test harness or host) drives the load
// and run controls; the core is the slave.
interface sap_cpu_if #(
    parameter int DATA_W = 8
);
    logic              prog_en;
    logic [DATA_W-1:0] prog_data;
    logic              prog_valid;
    logic              prog_ready;
    logic              load_done;
    logic              run_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              carry;
    logic              zero;
    logic              halted;

    modport master (
        output prog_en, prog_data, prog_valid, run_en,
        input  prog_ready, load_done, out_data, out_valid, carry, zero, halted
    );

    modport slave (
        input  prog_en, prog_data, prog_valid, run_en,
        output prog_ready, load_done, out_data, out_valid, carry, zero, halted
    );
endinterface

// File: rtl/sap_cpu_core.sv
// SAP-style accumulator CPU with an internal register-file RAM that is loaded
// through a valid/ready handshake, then executed with a two-cycle
// FETCH/EXEC instruction cycle. The RAM read is combinational and all RAM
// words clear on reset. Legal only for DATA_W >= 4 + ADDR_W.
module sap_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    sap_cpu_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_PROG   = 3'd1,
        ST_LOADED = 3'd2,
        ST_FETCH  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   pc_r, wr_ptr_r;
    logic [DATA_W-1:0]   ir_r, a_r;
    logic                cf_r, zf_r;
    logic [DATA_W-1:0]   ram_r [DEPTH];
    logic [DATA_W-1:0]   out_data_r;
    logic                out_valid_r, prog_ready_r, load_done_r, halted_r;

    logic [3:0]          opcode_s;
    logic [ADDR_W-1:0]   operand_s;
    logic [DATA_W-1:0]   mem_op_s, diff_s;
    logic [DATA_W:0]     sum_s;
    logic                ram_we_s;
    logic [ADDR_W-1:0]   ram_waddr_s;
    logic [DATA_W-1:0]   ram_wdata_s;

    assign opcode_s  = ir_r[DATA_W-1 -: 4];
    assign operand_s = ir_r[ADDR_W-1:0];
    assign mem_op_s  = ram_r[operand_s];
    assign sum_s     = {1'b0, a_r} + {1'b0, mem_op_s};
    assign diff_s    = a_r - mem_op_s;

    // Next-state decode plus the single RAM write port (load word or STA).
    always_comb begin
        state_s     = state_r;
        ram_we_s    = 1'b0;
        ram_waddr_s = wr_ptr_r;
        ram_wdata_s = bus.prog_data;
        case (state_r)
            ST_BOOT: begin
                if (bus.prog_en) state_s = ST_PROG;
                else             state_s = ST_FETCH;
            end
            ST_PROG: begin
                // prog_ready is high throughout PROG, so valid alone completes a handshake
                if (bus.prog_valid) ram_we_s = 1'b1;
                else                ram_we_s = 1'b0;
                if (!bus.prog_en)                                state_s = ST_FETCH;
                else if (bus.prog_valid && wr_ptr_r == ADDR_LAST) state_s = ST_LOADED;
                else                                             state_s = ST_PROG;
            end
            ST_LOADED: begin
                if (!bus.prog_en) state_s = ST_FETCH;
                else              state_s = ST_LOADED;
            end
            ST_FETCH: begin
                if (bus.run_en) state_s = ST_EXEC;
                else            state_s = ST_FETCH;
            end
            ST_EXEC: begin
                if (opcode_s == OP_HLT) state_s = ST_HALT;
                else                    state_s = ST_FETCH;
                if (opcode_s == OP_STA) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = operand_s;
                    ram_wdata_s = a_r;
                end else begin
                    ram_we_s    = 1'b0;
                end
            end
            ST_HALT: begin
                if (bus.prog_en) state_s = ST_PROG;
                else             state_s = ST_HALT;
            end
            default: state_s = ST_BOOT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_BOOT;
        else        state_r <= state_s;
    end

    // Program RAM: cleared on reset so no partially written word survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ram_r[i] <= {DATA_W{1'b0}};
        end else if (ram_we_s) begin
            ram_r[ram_waddr_s] <= ram_wdata_s;
        end
    end

    // Architectural registers: PC, IR, accumulator, flags, load pointer, output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= {ADDR_W{1'b0}};
            wr_ptr_r    <= {ADDR_W{1'b0}};
            ir_r        <= {DATA_W{1'b0}};
            a_r         <= {DATA_W{1'b0}};
            cf_r        <= 1'b0;
            zf_r        <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                ST_BOOT, ST_HALT: begin
                    if (bus.prog_en) wr_ptr_r <= {ADDR_W{1'b0}};
                end
                ST_PROG: begin
                    if (bus.prog_valid) wr_ptr_r <= wr_ptr_r + ADDR_ONE;
                    if (!bus.prog_en)   pc_r     <= {ADDR_W{1'b0}};
                end
                ST_LOADED: begin
                    if (!bus.prog_en) pc_r <= {ADDR_W{1'b0}};
                end
                ST_FETCH: begin
                    if (bus.run_en) begin
                        ir_r <= ram_r[pc_r];
                        pc_r <= pc_r + ADDR_ONE;
                    end
                end
                ST_EXEC: begin
                    case (opcode_s)
                        OP_LDA: a_r <= mem_op_s;
                        OP_ADD: begin
                            {cf_r, a_r} <= sum_s;
                            zf_r        <= (sum_s[DATA_W-1:0] == {DATA_W{1'b0}});
                        end
                        OP_SUB: begin
                            a_r  <= diff_s;
                            cf_r <= (a_r >= mem_op_s);
                            zf_r <= (diff_s == {DATA_W{1'b0}});
                        end
                        OP_LDI: a_r <= {{(DATA_W-ADDR_W){1'b0}}, operand_s};
                        OP_JMP: pc_r <= operand_s;
                        OP_JC:  if (cf_r) pc_r <= operand_s;
                        OP_JZ:  if (zf_r) pc_r <= operand_s;
                        OP_OUT: begin
                            out_data_r  <= a_r;
                            out_valid_r <= 1'b1;
                        end
                        default: ;  // NOP, STA (RAM port), HLT (state only), unused opcodes
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Status outputs registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_ready_r <= 1'b0;
            load_done_r  <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            prog_ready_r <= (state_s == ST_PROG);
            load_done_r  <= (state_s == ST_LOADED);
            halted_r     <= (state_s == ST_HALT);
        end
    end

    assign bus.prog_ready = prog_ready_r;
    assign bus.load_done  = load_done_r;
    assign bus.halted     = halted_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.carry      = cf_r;
    assign bus.zero       = zf_r;
endmodule

// File: tb/tb_sap_cpu_core.sv
// Randomized self-checking bench for sap_cpu_core: programs are loaded
// through the handshake and compared instruction by instruction against an
// instruction-set model of the SAP machine.
module tb_sap_cpu_core;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    sap_cpu_if #(.DATA_W(8)) bus ();

    sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ISA-level model state
    int m_mem [16];
    int m_pc, m_a, m_cf, m_zf, m_outd, m_out, m_halt;
    logic [7:0] prog_buf [16];
    bit h;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog_buf[i] = 8'h00;
    endtask

    // One instruction of the SAP machine, straight from the ISA rules.
    task automatic model_exec();
        int ir, op, n, t;
        ir = m_mem[m_pc];
        m_pc = (m_pc + 1) % 16;
        op = (ir >> 4) & 15;
        n  = ir & 15;
        m_out = 0;
        case (op)
            1: m_a = m_mem[n];
            2: begin
                t = m_a + m_mem[n];
                m_cf = (t > 255) ? 1 : 0;
                m_a = t % 256;
                m_zf = (m_a == 0) ? 1 : 0;
            end
            3: begin
                m_cf = (m_a >= m_mem[n]) ? 1 : 0;
                m_a = (m_a + 256 - m_mem[n]) % 256;
                m_zf = (m_a == 0) ? 1 : 0;
            end
            4: m_mem[n] = m_a;
            5: m_a = n;
            6: m_pc = n;
            7: if (m_cf == 1) m_pc = n;
            8: if (m_zf == 1) m_pc = n;
            14: begin m_out = 1; m_outd = m_a; end
            15: m_halt = 1;
            default: ;
        endcase
    endtask

    // Drop rst_n now (possibly mid-cycle), check the reset outputs, release mid-cycle.
    task automatic reset_pulse();
        rst_n = 1'b0;
        bus.prog_en = 1'b1;
        bus.prog_valid = 1'b0;
        bus.run_en = 1'b0;
        bus.prog_data = 8'h00;
        #1;
        check_eq("rst_out_data",   32'(bus.out_data), 32'h0);
        check_eq("rst_out_valid",  32'(bus.out_valid), 32'h0);
        check_eq("rst_prog_ready", 32'(bus.prog_ready), 32'h0);
        check_eq("rst_load_done",  32'(bus.load_done), 32'h0);
        check_eq("rst_halted",     32'(bus.halted), 32'h0);
        check_eq("rst_carry",      32'(bus.carry), 32'h0);
        check_eq("rst_zero",       32'(bus.zero), 32'h0);
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        m_pc = 0; m_a = 0; m_cf = 0; m_zf = 0; m_outd = 0; m_out = 0; m_halt = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Enter PROG (from BOOT or HALT), load n_load words of prog_buf, run.
    // stall_mode: 0 none, 1 random, 2 five cycles before every fetch.
    // valid_mode: 0 random prog_valid, 1 toggles every cycle.
    task automatic run_program(input int n_load, input int stall_mode, input int valid_mode,
                               input int rst_at, input int max_instr, output bit halted_o);
        int i, guard, ns;
        bit hs;
        halted_o = 1'b0;
        bus.prog_en = 1'b1;
        bus.run_en = 1'b0;
        bus.prog_valid = 1'b0;
        step();
        check_eq("prog_entry_ready", 32'(bus.prog_ready), 32'h1);
        check_eq("prog_entry_halted", 32'(bus.halted), 32'h0);
        m_halt = 0;
        i = 0;
        guard = 0;
        while (i < n_load && guard < 200) begin
            bus.prog_data = prog_buf[i];
            bus.prog_valid = (valid_mode == 1) ? guard[0] : 1'($urandom_range(0, 1));
            hs = bus.prog_ready && bus.prog_valid;
            step();
            if (hs) begin
                m_mem[i] = prog_buf[i];
                i++;
            end
            guard++;
        end
        check_eq("load_count", 32'(i), 32'(n_load));
        bus.prog_valid = 1'b0;
        if (n_load == 16) begin
            check_eq("loaded_done", 32'(bus.load_done), 32'h1);
            check_eq("loaded_ready", 32'(bus.prog_ready), 32'h0);
            bus.prog_valid = 1'b1;   // ignored outside PROG
            bus.prog_data = 8'hFF;
            step();
            check_eq("loaded_hold", 32'(bus.load_done), 32'h1);
            bus.prog_valid = 1'b0;
        end else begin
            check_eq("abort_done", 32'(bus.load_done), 32'h0);
            check_eq("abort_ready", 32'(bus.prog_ready), 32'h1);
        end
        bus.prog_en = 1'b0;
        step();
        check_eq("fetch_entry_done", 32'(bus.load_done), 32'h0);
        check_eq("fetch_entry_ready", 32'(bus.prog_ready), 32'h0);
        m_pc = 0;
        for (int k = 0; k < max_instr && m_halt == 0; k++) begin
            ns = (stall_mode == 2) ? 5 : (stall_mode == 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            for (int s = 0; s < ns; s++) begin
                bus.run_en = 1'b0;
                bus.prog_en = 1'($urandom_range(0, 1));
                bus.prog_valid = 1'($urandom_range(0, 1));
                step();
                check_eq("stall_ov", 32'(bus.out_valid), 32'h0);
                check_eq("stall_od", 32'(bus.out_data), 32'(m_outd));
                check_eq("stall_halted", 32'(bus.halted), 32'h0);
            end
            bus.run_en = 1'b1;
            bus.prog_en = 1'($urandom_range(0, 1));
            bus.prog_valid = 1'($urandom_range(0, 1));
            step();
            check_eq("fetch_ov", 32'(bus.out_valid), 32'h0);
            if (k == rst_at) begin
                reset_pulse();
                return;
            end
            bus.prog_en = 1'b0;
            bus.run_en = 1'($urandom_range(0, 1));
            step();
            model_exec();
            check_eq("exec_carry", 32'(bus.carry), 32'(m_cf));
            check_eq("exec_zero", 32'(bus.zero), 32'(m_zf));
            check_eq("exec_halted", 32'(bus.halted), 32'(m_halt));
            check_eq("exec_ov", 32'(bus.out_valid), 32'(m_out));
            check_eq("exec_od", 32'(bus.out_data), 32'(m_outd));
        end
        if (m_halt == 1) begin
            for (int c = 0; c < 3; c++) begin
                bus.prog_en = 1'b0;
                bus.run_en = 1'($urandom_range(0, 1));
                bus.prog_valid = 1'($urandom_range(0, 1));
                step();
                check_eq("halt_hold", 32'(bus.halted), 32'h1);
                check_eq("halt_ov", 32'(bus.out_valid), 32'h0);
                check_eq("halt_carry", 32'(bus.carry), 32'(m_cf));
                check_eq("halt_zero", 32'(bus.zero), 32'(m_zf));
            end
            bus.prog_valid = 1'b0;
            halted_o = 1'b1;
        end
    endtask

    initial begin
        bus.prog_en = 1'b0;
        bus.prog_valid = 1'b0;
        bus.prog_data = 8'h00;
        bus.run_en = 1'b0;
        #1;
        reset_pulse();

        // LDA 14, ADD 15, OUT, HLT with toggling prog_valid
        clear_prog();
        prog_buf[0] = 8'h1E; prog_buf[1] = 8'h2F; prog_buf[2] = 8'hE0; prog_buf[3] = 8'hF0;
        prog_buf[14] = 8'h28; prog_buf[15] = 8'h0E;
        run_program(16, 0, 1, -1, 20, h);
        check_eq("demo_halted", 32'(h), 32'h1);
        check_eq("demo_out", 32'(bus.out_data), 32'h36);
        check_eq("demo_carry", 32'(bus.carry), 32'h0);
        check_eq("demo_zero", 32'(bus.zero), 32'h0);

        // LDI 5, SUB word 0x05, JZ 10 -> OUT 0, HLT (reloaded straight from HALT)
        clear_prog();
        prog_buf[0] = 8'h55; prog_buf[1] = 8'h33; prog_buf[2] = 8'h8A; prog_buf[3] = 8'h05;
        prog_buf[10] = 8'hE0; prog_buf[11] = 8'hF0;
        run_program(16, 0, 0, -1, 20, h);
        check_eq("sub_halted", 32'(h), 32'h1);
        check_eq("sub_out", 32'(bus.out_data), 32'h0);
        check_eq("sub_carry", 32'(bus.carry), 32'h1);
        check_eq("sub_zero", 32'(bus.zero), 32'h1);

        // 0xF0 + 0x20 -> 0x10 with carry; JC taken, JZ not taken
        clear_prog();
        prog_buf[0] = 8'h1D; prog_buf[1] = 8'h2E; prog_buf[2] = 8'h76; prog_buf[3] = 8'hF0;
        prog_buf[6] = 8'h8C; prog_buf[7] = 8'hE0; prog_buf[8] = 8'hF0;
        prog_buf[12] = 8'hF0; prog_buf[13] = 8'hF0; prog_buf[14] = 8'h20;
        run_program(16, 0, 0, -1, 20, h);
        check_eq("add_halted", 32'(h), 32'h1);
        check_eq("add_out", 32'(bus.out_data), 32'h10);
        check_eq("add_carry", 32'(bus.carry), 32'h1);
        check_eq("add_zero", 32'(bus.zero), 32'h0);

        // Demo program again with a 5-cycle run_en stall before every fetch
        clear_prog();
        prog_buf[0] = 8'h1E; prog_buf[1] = 8'h2F; prog_buf[2] = 8'hE0; prog_buf[3] = 8'hF0;
        prog_buf[14] = 8'h28; prog_buf[15] = 8'h0E;
        run_program(16, 2, 0, -1, 20, h);
        check_eq("stall_demo_out", 32'(bus.out_data), 32'h36);

        // Random programs, sometimes partially loaded
        for (int it = 0; it < 20; it++) begin
            int nl;
            if (!h) reset_pulse();
            for (int w = 0; w < 16; w++) prog_buf[w] = 8'($urandom_range(0, 255));
            nl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
            run_program(nl, 1, int'($urandom_range(0, 1)), -1, 30, h);
        end

        // Reset during EXEC of STA, then a partial load reading the STA target
        if (!h) reset_pulse();
        clear_prog();
        prog_buf[0] = 8'h57; prog_buf[1] = 8'h49; prog_buf[2] = 8'hF0; prog_buf[9] = 8'h33;
        run_program(16, 0, 0, 1, 10, h);
        clear_prog();
        prog_buf[0] = 8'h19; prog_buf[1] = 8'hE0; prog_buf[2] = 8'hF0;
        run_program(3, 0, 0, -1, 10, h);
        check_eq("sta_rst_halted", 32'(h), 32'h1);
        check_eq("sta_rst_word", 32'(bus.out_data), 32'h0);
        bus.prog_en = 1'b1;
        step();
        check_eq("halt_to_prog_ready", 32'(bus.prog_ready), 32'h1);
        check_eq("halt_to_prog_halted", 32'(bus.halted), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
